// File: rtl/sram2rw_fifo_ctrl_if.sv
// Producer/consumer handshake bundle for sram2rw_fifo_ctrl.
// master = the producer/consumer side, slave = the FIFO controller.
interface sram2rw_fifo_ctrl_if #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DATA_W = 4
);
    logic              enq_valid;
    logic              enq_ready;
    logic [DATA_W-1:0] enq_data;
    logic              deq_valid;
    logic              deq_ready;
    logic [DATA_W-1:0] deq_data;
    logic [ADDR_W:0]   count;

    modport master (
        output enq_valid, enq_data, deq_ready,
        input  enq_ready, deq_valid, deq_data, count
    );

    modport slave (
        input  enq_valid, enq_data, deq_ready,
        output enq_ready, deq_valid, deq_data, count
    );
endinterface

// File: rtl/sram2rw_fifo_ctrl.sv
// FIFO controller over a 2RW SRAM macro (port 1 write, port 2 read) with a 2-entry output
// buffer that hides the registered read latency. Define FIFO_BYPASS_EN for the 1-cycle bypass.
module sram2rw_fifo_ctrl #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DATA_W = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    sram2rw_fifo_ctrl_if.slave  fifo_if,
    output logic                sram_csb1_o,
    output logic                sram_web1_o,
    output logic                sram_oeb1_o,
    output logic [ADDR_W-1:0]   sram_a1_o,
    output logic [DATA_W-1:0]   sram_i1_o,
    output logic                sram_csb2_o,
    output logic                sram_oeb2_o,
    output logic                sram_web2_o,
    output logic [ADDR_W-1:0]   sram_a2_o,
    input  logic [DATA_W-1:0]   sram_o2_i
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] FullCnt = (ADDR_W+1)'(DEPTH);

    logic [ADDR_W-1:0]            wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]            rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]              sram_cnt_q, sram_cnt_d;
    logic                         inflight_q, inflight_d;
    logic [1:0]                   buf_cnt_q, buf_cnt_d;
    logic [1:0][DATA_W-1:0]       buf_q, buf_d;

    logic       enq_fire, deq_fire, rd_issue, bypass, sram_wr;
    logic [2:0] occ;

    // Held low during reset so no write strobe can escape while state is cleared.
    assign fifo_if.enq_ready = ~rst_i & (sram_cnt_q != FullCnt);
    assign enq_fire          = fifo_if.enq_valid & fifo_if.enq_ready;
    assign fifo_if.deq_valid = (buf_cnt_q != 2'd0);
    assign deq_fire          = fifo_if.deq_valid & fifo_if.deq_ready;
    assign fifo_if.deq_data  = buf_q[0];
    assign fifo_if.count     = sram_cnt_q + (ADDR_W+1)'(inflight_q) + (ADDR_W+1)'(buf_cnt_q);

    // Buffer slots that will be taken after this edge, counting the word already in flight.
    assign occ      = {1'b0, buf_cnt_q} + {2'b00, inflight_q} - {2'b00, deq_fire};
    assign rd_issue = (sram_cnt_q != '0) & (occ < 3'd2);

`ifdef FIFO_BYPASS_EN
    assign bypass = enq_fire & (sram_cnt_q == '0) & ~inflight_q &
                    (({1'b0, buf_cnt_q} - {2'b00, deq_fire}) < 3'd2);
`else
    assign bypass = 1'b0;
`endif

    assign sram_wr = enq_fire & ~bypass;

    assign sram_csb1_o = ~sram_wr;
    assign sram_web1_o = ~sram_wr;
    assign sram_oeb1_o = 1'b1;
    assign sram_a1_o   = wr_ptr_q;
    assign sram_i1_o   = fifo_if.enq_data;

    assign sram_csb2_o = ~rd_issue;
    assign sram_oeb2_o = ~rd_issue;
    assign sram_web2_o = 1'b1;
    assign sram_a2_o   = rd_ptr_q;

    always_comb begin
        wr_ptr_d   = wr_ptr_q + ADDR_W'(sram_wr);
        rd_ptr_d   = rd_ptr_q + ADDR_W'(rd_issue);
        sram_cnt_d = sram_cnt_q + (ADDR_W+1)'(sram_wr) - (ADDR_W+1)'(rd_issue);
        inflight_d = rd_issue;
        buf_d      = buf_q;
        buf_cnt_d  = buf_cnt_q;
        if (deq_fire) begin
            buf_d[0]  = buf_q[1];
            buf_cnt_d = buf_cnt_q - 2'd1;
        end
        // Push lands in the first free slot after any pop; a read return and a bypass never coincide.
        if (inflight_q | bypass) begin
            buf_d[buf_cnt_d[0]] = inflight_q ? sram_o2_i : fifo_if.enq_data;
            buf_cnt_d           = buf_cnt_d + 2'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            sram_cnt_q <= '0;
            inflight_q <= 1'b0;
            buf_cnt_q  <= '0;
            buf_q      <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            sram_cnt_q <= sram_cnt_d;
            inflight_q <= inflight_d;
            buf_cnt_q  <= buf_cnt_d;
            buf_q      <= buf_d;
        end
    end
endmodule
